// File: rtl/led_matrix_scan_if.sv
// Game-side bus into the LED matrix scanner: back-buffer writes, swap request/ack and row/column drive.
interface led_matrix_scan_if #(
    parameter int COLS = 8
) ();
    logic            wr_en;
    logic [2:0]      wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic [7:0]      row_sel;
    logic [COLS-1:0] col_data;
    logic            frame_start;
    logic            swap_ack;

    modport master (
        output wr_en, wr_row, wr_data, swap_req,
        input  row_sel, col_data, frame_start, swap_ack
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req,
        output row_sel, col_data, frame_start, swap_ack
    );
endinterface

// File: rtl/led_matrix_scan.sv
// Double-buffered 8-row LED matrix scanner; one row lit at a time with blanking, stepped by scan_clk rising edges.
// Outputs registered, one clk50 cycle after the qualifying tick; no backpressure (writes always accepted).
module led_matrix_scan #(
    parameter int COLS        = 8,
    parameter int ROW_DWELL   = 16,
    parameter int BLANK_TICKS = 1
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             scan_clk,
    led_matrix_scan_if.slave bus
);
    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(ROW_DWELL - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_TICKS - 1);

    state_t          r_state, w_state_nxt;
    logic            r_sc_q;
    logic            w_tick;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [2:0]      r_row, w_row_nxt;
    logic            r_front, w_front_nxt;
    logic            r_pending, w_pending_nxt;
    logic            w_boundary;
    logic            w_back;
    logic [COLS-1:0] r_buf [2][8];

    logic [7:0]      r_row_sel, w_row_sel_nxt;
    logic [COLS-1:0] r_col, w_col_nxt;
    logic            r_frame_start, w_frame_start_nxt;
    logic            r_swap_ack, w_swap_ack_nxt;

    assign w_tick = scan_clk & ~r_sc_q;
    assign w_back = ~r_front;

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            r_state       <= ST_BLANK;
            r_sc_q        <= 1'b0;
            r_cnt         <= 8'd0;
            r_row         <= 3'd0;
            r_front       <= 1'b0;
            r_pending     <= 1'b0;
            r_row_sel     <= 8'd0;
            r_col         <= '0;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sc_q        <= scan_clk;
            r_cnt         <= w_cnt_nxt;
            r_row         <= w_row_nxt;
            r_front       <= w_front_nxt;
            r_pending     <= w_pending_nxt;
            r_row_sel     <= w_row_sel_nxt;
            r_col         <= w_col_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_swap_ack    <= w_swap_ack_nxt;
        end
    end

    // Writes target whichever buffer is "back" before this edge, even if a swap lands on the same edge.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    r_buf[b][r] <= '0;
                end
            end
        end else if (bus.wr_en) begin
            r_buf[w_back][bus.wr_row] <= bus.wr_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_boundary  = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = 8'd0;
                        w_row_nxt   = r_row + 3'd1;
                        w_boundary  = (r_row == 3'd7);
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = ST_BLANK;
            endcase
        end
        // Only a request pending before the boundary edge is serviced; one raised on it waits a frame.
        w_front_nxt   = r_front ^ (w_boundary & r_pending);
        w_pending_nxt = (w_boundary & r_pending) ? 1'b0 : (r_pending | bus.swap_req);
    end

    always_comb begin
        w_row_sel_nxt     = r_row_sel;
        w_col_nxt         = r_col;
        w_frame_start_nxt = 1'b0;
        w_swap_ack_nxt    = w_boundary & r_pending;
        if (r_state == ST_BLANK && w_state_nxt == ST_SHOW) begin
            w_row_sel_nxt     = 8'd1 << r_row;
            w_col_nxt         = r_buf[r_front][r_row];
            w_frame_start_nxt = (r_row == 3'd0);
        end else if (r_state == ST_SHOW && w_state_nxt == ST_BLANK) begin
            w_row_sel_nxt = 8'd0;
            w_col_nxt     = '0;
        end
    end

    assign bus.row_sel     = r_row_sel;
    assign bus.col_data    = r_col;
    assign bus.frame_start = r_frame_start;
    assign bus.swap_ack    = r_swap_ack;
endmodule
